// File: rtl/alu_exec_if.sv
// Execute-stage bus: instruction fields flowing into the ALU and the result,
// write-back request and stall flowing back out to the ALU/EX latch and the
// pipeline control.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            stg_x;
    logic            in_valid;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            save_to_reg_in;
    logic [4:0]      rd;
    logic [XLEN-1:0] c;
    logic            save_to_reg;
    logic            busy;

    // Upstream pipeline side: presents the instruction, observes the result.
    modport master (
        output stg_x, in_valid, op, a, b, rd_in, save_to_reg_in,
        input  rd, c, save_to_reg, busy
    );

    // Execute unit side.
    modport slave (
        input  stg_x, in_valid, op, a, b, rd_in, save_to_reg_in,
        output rd, c, save_to_reg, busy
    );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle integer ALU plus an iterative 32-step
// multiply/divide engine. While the engine runs, busy holds the upstream
// stages; the finished result is presented in the DONE state for exactly one
// cycle so the ALU/EX latch captures it once.
module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic      stg_clk,
    input  logic      reset,
    alu_exec_if.slave bus
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_IT  = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negation.
    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed value (MIN_INT maps onto itself as unsigned 2^31).
    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? f_neg(x) : x;
    endfunction

    state_t            state_r;
    logic [5:0]        cnt_r;
    logic [3:0]        op_r;
    logic [4:0]        rd_r;
    logic              save_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2*XLEN-1:0] acc_r;

    logic              is_mop_s;
    logic              is_div_s;
    logic              is_sdiv_s;
    logic              start_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN-1:0]   alu_res_s;
    logic [XLEN-1:0]   m_res_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN+1:0]   div_trial_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [4:0]        shamt_s;

    assign is_mop_s   = (bus.op >= OP_MUL);
    assign is_div_s   = (bus.op >= OP_DIV);
    assign is_sdiv_s  = (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign start_s    = (state_r == IDLE) && bus.in_valid && is_mop_s && !bus.stg_x;
    assign div_zero_s = (bus.b == ZERO_W);
    assign div_ovf_s  = is_sdiv_s && (bus.a == MIN_INT) && (bus.b == ALL_ONES);
    assign mag_a_s    = is_sdiv_s ? f_abs(bus.a) : bus.a;
    assign mag_b_s    = is_sdiv_s ? f_abs(bus.b) : bus.b;
    assign shamt_s    = bus.b[4:0];

    // Base integer ALU, fully combinational.
    always_comb begin
        alu_res_s = ZERO_W;
        case (bus.op)
            OP_ADD:  alu_res_s = bus.a + bus.b;
            OP_SUB:  alu_res_s = bus.a - bus.b;
            OP_SLL:  alu_res_s = bus.a << shamt_s;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  alu_res_s = bus.a ^ bus.b;
            OP_SRL:  alu_res_s = bus.a >> shamt_s;
            OP_SRA:  alu_res_s = $signed(bus.a) >>> shamt_s;
            OP_OR:   alu_res_s = bus.a | bus.b;
            OP_AND:  alu_res_s = bus.a & bus.b;
            default: alu_res_s = ZERO_W;
        endcase
    end

    // One shift-add step: accumulator holds {partial high, remaining multiplier}.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
        if (acc_r[0]) begin
            mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[2*XLEN-1:1]};
        end
    end

    // One restoring-division step: accumulator holds {remainder, dividend/quotient}.
    always_comb begin
        div_trial_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, opnd_r};
        if (div_trial_s[XLEN+1]) begin
            div_next_s = {acc_r[2*XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end
    end

    // Final M-extension result with sign fix-up, valid in DONE.
    always_comb begin
        m_res_s = ZERO_W;
        case (op_r)
            OP_MUL:   m_res_s = acc_r[XLEN-1:0];
            OP_MULHU: m_res_s = acc_r[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:  m_res_s = neg_q_r ? f_neg(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
            OP_REM,
            OP_REMU:  m_res_s = neg_r_r ? f_neg(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
            default:  m_res_s = ZERO_W;
        endcase
    end

    // Output steering: reset and flush force a quiet bubble; DONE replays captured fields.
    always_comb begin
        bus.busy        = 1'b0;
        bus.save_to_reg = 1'b0;
        bus.rd          = 5'd0;
        bus.c           = ZERO_W;
        if (reset) begin
            bus.busy        = 1'b0;
            bus.save_to_reg = 1'b0;
            bus.rd          = 5'd0;
            bus.c           = ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.busy        = start_s;
                    bus.save_to_reg = bus.in_valid && bus.save_to_reg_in && !is_mop_s && !bus.stg_x;
                    bus.rd          = bus.rd_in;
                    bus.c           = is_mop_s ? ZERO_W : alu_res_s;
                end
                MUL, DIV: begin
                    bus.busy        = !bus.stg_x;
                    bus.save_to_reg = 1'b0;
                    bus.rd          = rd_r;
                    bus.c           = ZERO_W;
                end
                DONE: begin
                    bus.busy        = 1'b0;
                    bus.save_to_reg = save_r && !bus.stg_x;
                    bus.rd          = rd_r;
                    bus.c           = m_res_s;
                end
                default: begin
                    bus.busy        = 1'b0;
                    bus.save_to_reg = 1'b0;
                    bus.rd          = 5'd0;
                    bus.c           = ZERO_W;
                end
            endcase
        end
    end

    // Sequencer: captures M-ops, iterates the engine, and returns to IDLE after DONE.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            op_r    <= 4'd0;
            rd_r    <= 5'd0;
            save_r  <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            opnd_r  <= ZERO_W;
            acc_r   <= {2*XLEN{1'b0}};
        end else if (bus.stg_x) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        op_r   <= bus.op;
                        rd_r   <= bus.rd_in;
                        save_r <= bus.save_to_reg_in;
                        cnt_r  <= 6'd0;
                        if (is_div_s && div_zero_s) begin
                            // Quotient all ones, remainder is the dividend as given.
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            acc_r   <= {bus.a, ALL_ONES};
                            state_r <= DONE;
                        end else if (div_ovf_s) begin
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            acc_r   <= {ZERO_W, MIN_INT};
                            state_r <= DONE;
                        end else begin
                            neg_q_r <= is_sdiv_s && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                            neg_r_r <= is_sdiv_s && bus.a[XLEN-1];
                            opnd_r  <= is_div_s ? mag_b_s : bus.b;
                            acc_r   <= {ZERO_W, (is_div_s ? mag_a_s : bus.a)};
                            state_r <= is_div_s ? DIV : MUL;
                        end
                    end
                end
                MUL: begin
                    acc_r <= mul_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == LAST_IT) begin
                        state_r <= DONE;
                    end
                end
                DIV: begin
                    acc_r <= div_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == LAST_IT) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    cnt_r   <= 6'd0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: base ops, iterative multiply/divide with busy
// timing, divide special cases, flush and asynchronous reset.
module tb_alu_exec;

    logic stg_clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec #(.XLEN(32)) dut (
        .stg_clk (stg_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial stg_clk = 1'b0;
    always #5 stg_clk = ~stg_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a base op at posedge+1 and check it at the following negedge.
    task automatic base_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] r, input logic v,
                           input logic s, input logic [31:0] ec, input logic es);
        @(posedge stg_clk); #1;
        bus.in_valid = v; bus.op = o; bus.a = x; bus.b = y;
        bus.rd_in = r; bus.save_to_reg_in = s;
        @(negedge stg_clk);
        check_eq({tag, "_c"}, bus.c, ec);
        check_eq({tag, "_rd"}, 32'(bus.rd), 32'(r));
        check_eq({tag, "_save"}, 32'(bus.save_to_reg), 32'(es));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Present an M-op (caller is at posedge+1), count busy cycles, check DONE outputs.
    task automatic m_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input logic [31:0] ec,
                        input int ebusy);
        int nb;
        bit save_seen;
        nb = 0;
        save_seen = 1'b0;
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        bus.rd_in = r; bus.save_to_reg_in = 1'b1;
        @(negedge stg_clk);
        while (bus.busy && nb < 100) begin
            nb++;
            if (bus.save_to_reg) save_seen = 1'b1;
            @(negedge stg_clk);
        end
        check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(ebusy));
        check_eq({tag, "_save_while_busy"}, 32'(save_seen), 32'd0);
        // DONE must use captured fields, not the live inputs.
        bus.rd_in = r ^ 5'h1F; bus.a = 32'd0; bus.b = 32'd0;
        #1;
        check_eq({tag, "_c"}, bus.c, ec);
        check_eq({tag, "_rd"}, 32'(bus.rd), 32'(r));
        check_eq({tag, "_save"}, 32'(bus.save_to_reg), 32'd1);
        @(posedge stg_clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.stg_x = 1'b0; bus.in_valid = 1'b1; bus.op = 4'd0;
        bus.a = 32'd5; bus.b = 32'hFFFF_FFFD; bus.rd_in = 5'd3; bus.save_to_reg_in = 1'b1;
        #3;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_save", 32'(bus.save_to_reg), 32'd0);
        check_eq("rst_rd", 32'(bus.rd), 32'd0);
        check_eq("rst_c", bus.c, 32'd0);
        @(negedge stg_clk);
        reset = 1'b0;

        // Base ops: tag, op, a, b, rd, valid, save_in, expected c, expected save.
        base_op("add",    4'd0, 32'd5,        32'hFFFF_FFFD, 5'd3,  1'b1, 1'b1, 32'd2,         1'b1);
        base_op("sra",    4'd7, 32'h8000_0000, 32'd4,        5'd4,  1'b1, 1'b1, 32'hF800_0000, 1'b1);
        base_op("sub",    4'd1, 32'd3,        32'd5,         5'd5,  1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        base_op("sll",    4'd2, 32'd1,        32'h0000_003F, 5'd6,  1'b1, 1'b1, 32'h8000_0000, 1'b1);
        base_op("slt",    4'd3, 32'hFFFF_FFFF, 32'd1,        5'd7,  1'b1, 1'b1, 32'd1,         1'b1);
        base_op("sltu",   4'd4, 32'hFFFF_FFFF, 32'd1,        5'd8,  1'b1, 1'b1, 32'd0,         1'b1);
        base_op("xor",    4'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd9, 1'b1, 1'b1, 32'hFF00_0FF0, 1'b1);
        base_op("srl",    4'd6, 32'h8000_0000, 32'd4,        5'd10, 1'b1, 1'b0, 32'h0800_0000, 1'b0);
        base_op("or",     4'd8, 32'h1200_0034, 32'h0056_7800, 5'd11, 1'b1, 1'b1, 32'h1256_7834, 1'b1);
        base_op("and",    4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd12, 1'b1, 1'b1, 32'h0F00_0F00, 1'b1);
        base_op("bubble", 4'd0, 32'd1,        32'd1,         5'd13, 1'b0, 1'b1, 32'd2,         1'b0);

        // M-ops: tag, op, a, b, rd, expected c, busy cycles.
        @(posedge stg_clk); #1;
        m_op("mul",      4'd10, 32'hFFFF_FFFF, 32'd2,         5'd14, 32'hFFFF_FFFE, 33);
        m_op("mulhu",    4'd11, 32'hFFFF_FFFF, 32'd2,         5'd15, 32'd1,         33);
        m_op("mul2",     4'd10, 32'd12345,     32'd6789,      5'd16, 32'h04FE_D79D, 33);
        m_op("div",      4'd12, 32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 33);
        m_op("rem",      4'd14, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFF, 33);
        m_op("div_nn",   4'd12, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd19, 32'd14,        33);
        m_op("rem_nn",   4'd14, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd20, 32'hFFFF_FFFE, 33);
        m_op("remu",     4'd15, 32'd100,       32'd7,         5'd21, 32'd2,         33);
        m_op("remu_z",   4'd15, 32'd7,         32'd0,         5'd22, 32'd7,         1);
        m_op("divu_z",   4'd13, 32'd7,         32'd0,         5'd23, 32'hFFFF_FFFF, 1);
        m_op("div_ovf",  4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1);
        m_op("rem_ovf",  4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'd0,         1);

        // Flush in iteration 10 of a MUL.
        bus.in_valid = 1'b1; bus.op = 4'd10; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
        bus.rd_in = 5'd26; bus.save_to_reg_in = 1'b1;
        repeat (10) @(posedge stg_clk);
        #1;
        bus.stg_x = 1'b1;
        @(negedge stg_clk);
        check_eq("flush_busy", 32'(bus.busy), 32'd0);
        check_eq("flush_save", 32'(bus.save_to_reg), 32'd0);
        @(posedge stg_clk); #1;
        @(negedge stg_clk);
        check_eq("flush_mop_blocked", 32'(bus.busy), 32'd0);
        @(posedge stg_clk); #1;
        bus.stg_x = 1'b0; bus.in_valid = 1'b0;
        @(negedge stg_clk);
        check_eq("flush_no_restart", 32'(bus.busy), 32'd0);
        base_op("add_after_flush", 4'd0, 32'd40, 32'd2, 5'd27, 1'b1, 1'b1, 32'd42, 1'b1);

        // Asynchronous reset in the middle of a DIVU.
        @(posedge stg_clk); #1;
        bus.in_valid = 1'b1; bus.op = 4'd13; bus.a = 32'd1000; bus.b = 32'd3;
        bus.rd_in = 5'd9; bus.save_to_reg_in = 1'b1;
        repeat (5) @(posedge stg_clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_mid_save", 32'(bus.save_to_reg), 32'd0);
        check_eq("rst_mid_rd", 32'(bus.rd), 32'd0);
        check_eq("rst_mid_c", bus.c, 32'd0);
        bus.in_valid = 1'b0;
        @(posedge stg_clk); #1;
        reset = 1'b0;
        m_op("divu_after_rst", 4'd13, 32'd100, 32'd7, 5'd28, 32'd14, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage unit of the pipelined core: computes the result `c` plus the pass-through `rd` and `save_to_reg` that are registered by the ALU/EX stage latch on the next `stg_clk` edge. Base integer ops complete combinationally in the same cycle. The M-extension ops (multiply, divide, remainder) run on an iterative 32-cycle engine and assert `busy`; pipeline control uses `busy` to hold the upstream stages and the ID/EX latch until the result is ready.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `stg_clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stg_x` in 1: synchronous flush; aborts any in-flight operation.
- `in_valid` in 1: an instruction is present; 0 means bubble.
- `op` in 4: operation code.
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- `a`, `b` in 32: operands.
- `rd_in` in 5: destination register.
- `save_to_reg_in` in 1: write-back request.
- `rd` out 5: destination register, to the latch.
- `c` out 32: result, to the latch.
- `save_to_reg` out 1: write-back request, to the latch.
- `busy` out 1: stall request. While `busy` is 1, upstream holds `op`, `a`, `b`, `rd_in` and `save_to_reg_in` stable.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Registered state: 6-bit iteration counter, captured operands, `rd`, `save_to_reg`, sign flags, 64-bit accumulator.
- **IDLE, base op or bubble:**
  - `c` = combinational ALU result; `rd` = `rd_in`; `save_to_reg` = `in_valid & save_to_reg_in`; `busy` = 0.
  - Shift amount is `b[4:0]`. SLT/SLTU output 0 or 1.
- **IDLE, `in_valid` and op ≥ 10, `stg_x` = 0:**
  - `busy` = 1 combinationally in this cycle; `save_to_reg` = 0 (the latch captures a bubble).
  - Capture operands, `rd_in` and `save_to_reg_in`.
  - Next state:
    - DIV* with `b` = 0 → DONE, result precomputed. DIV/DIVU quotient = 0xFFFFFFFF. REM/REMU remainder = `a`.
    - DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF → DONE. Quotient = 0x80000000, remainder = 0.
    - Otherwise MUL ops → MUL, DIV ops → DIV. Counter cleared.
- **MUL:**
  - Unsigned shift-add, one multiplier bit per cycle, 32 iterations, then DONE.
  - MUL returns `product[31:0]`; MULHU returns `product[63:32]`.
- **DIV:**
  - Restoring division on magnitudes (signed ops take absolute values), one quotient bit per cycle, 32 iterations, then DONE.
  - Sign fix-up in DONE: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
- **DONE:**
  - `busy` = 0; `c` = final result; `rd` and `save_to_reg` taken from the captured values.
  - Inputs are ignored, so the held M instruction is not restarted. Next state is IDLE.
- **`stg_x`:**
  - From any state, next state is IDLE and the counter is cleared.
  - During the flush cycle: `busy` = 0 and `save_to_reg` = 0.
  - An M-op presented together with `stg_x` does not start.
- **Reset:**
  - Registered state returns to IDLE immediately; counter, accumulator and captured fields go to 0.
  - While `reset` = 1: `busy` = 0, `save_to_reg` = 0, `rd` = 0, `c` = 0.

## Timing
- Base ops: zero added latency. The result is captured by the latch at the end of the cycle in which it is presented.
- M-op presented in cycle N, normal path:
  - `busy` = 1 in cycles N..N+32 (33 cycles).
  - DONE in cycle N+33: `busy` = 0 and the valid result is captured at the end of N+33.
- Special-case divide: `busy` = 1 in cycle N only; result in cycle N+1.
- Back-to-back M-ops: the second one is presented after DONE and starts from IDLE. Minimum spacing is 34 cycles.
- `busy` is a combinational function of state, `in_valid`, `op`, `stg_x` and `reset`. It must not depend on `c`.
- Reset assertion mid-operation takes effect without waiting for a clock edge. The first edge after deassertion sees IDLE.

## Test plan
- ADD: `a`=5, `b`=0xFFFFFFFD, `rd_in`=3, `save_to_reg_in`=1 → same cycle `c`=2, `rd`=3, `save_to_reg`=1, `busy`=0. SRA: 0x80000000 >> 4 → 0xF8000000.
- MUL: `a`=0xFFFFFFFF, `b`=2 → `busy` high for 33 cycles with `save_to_reg`=0; then `c`=0xFFFFFFFE, `rd` = the captured `rd_in`. MULHU with the same operands → `c`=1.
- DIV: -7 / 2 → `c`=0xFFFFFFFD (-3). REM: -7 % 2 → `c`=0xFFFFFFFF (-1). REMU: 7 % 0 → `c`=7 with `busy` high for 1 cycle only.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → `c`=0x80000000; REM → `c`=0; each with `busy` high for 1 cycle.
- Flush: `stg_x` pulsed in iteration 10 of a MUL → `busy`=0 in that cycle, no write-back. A following ADD completes normally.
- Reset: `reset` asserted mid-DIV → outputs go to 0 and `busy`=0 immediately. After release, DIVU 100 / 7 → `c`=14 after 33 busy cycles.
